// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with busy scoreboard and clear sequencer.
// Define REGFILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_req,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data
);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            ready_q;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [XLEN-1:0] mem_q [NREGS];

    logic            run;
    logic            wb_hit;
    logic            alloc_hit;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    assign run       = (state_q == S_RUN);
    assign wb_hit    = run && wb_en && (wb_addr != '0);
    assign alloc_hit = run && alloc_en && (alloc_addr != '0);
    assign ready     = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (clear_req) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(NREGS - 1)) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Alloc is applied after wb so a newer producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (clear_req) begin
            busy_d = '0;
        end else begin
            if (wb_hit) begin
                busy_d[wb_addr] = 1'b0;
            end
            if (alloc_hit) begin
                busy_d[alloc_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (!run) begin
            mem_we = 1'b1;
        end else if (wb_hit) begin
            mem_we    = 1'b1;
            mem_waddr = wb_addr;
            mem_wdata = wb_data;
        end
    end

    // No reset on the array so it can map onto RAM; the sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            ra = rd_addr[p*AW +: AW];
            if (run && (ra != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (wb_hit && (ra == wb_addr)) begin
                    rd_data[p*XLEN +: XLEN] = wb_data;
                    rd_busy[p] = alloc_hit && (alloc_addr == ra);
                end else begin
                    rd_data[p*XLEN +: XLEN] = mem_q[ra];
                    rd_busy[p] = busy_q[ra];
                end
`else
                rd_data[p*XLEN +: XLEN] = mem_q[ra];
                rd_busy[p] = busy_q[ra];
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized bench for regfile_sb against an array-based model,
// plus a directed run of a NRD=3 / NREGS=16 / XLEN=64 instance.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                clear_req;
    logic                ready;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    logic         s_clear_req;
    logic         s_ready;
    logic [11:0]  s_rd_addr;
    logic [191:0] s_rd_data;
    logic [2:0]   s_rd_busy;
    logic         s_alloc_en;
    logic [3:0]   s_alloc_addr;
    logic         s_wb_en;
    logic [3:0]   s_wb_addr;
    logic [63:0]  s_wb_data;

    regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .clear_req(s_clear_req), .ready(s_ready),
        .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
        .alloc_en(s_alloc_en), .alloc_addr(s_alloc_addr),
        .wb_en(s_wb_en), .wb_addr(s_wb_addr), .wb_data(s_wb_data)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: architectural values, busy flags, clear cycles left.
    logic [31:0] m_mem [NREGS];
    bit          m_busy [NREGS];
    int          m_clr;

    task automatic exp_rd(input int a, output logic [31:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (m_clr != 0 || a == 0) return;
`ifdef REGFILE_BYPASS_EN
        if (wb_en && int'(wb_addr) == a) begin
            d = wb_data;
            b = alloc_en && int'(alloc_addr) == a;
            return;
        end
`endif
        d = m_mem[a];
        b = m_busy[a];
    endtask

    task automatic check_outputs();
        logic [31:0] d;
        logic b;
        int a;
        check("ready", 64'(ready), 64'(m_clr == 0));
        for (int p = 0; p < NRD; p++) begin
            a = int'(rd_addr[p*AW +: AW]);
            exp_rd(a, d, b);
            check($sformatf("rd_data%0d x%0d", p, a),
                  64'(rd_data[p*XLEN +: XLEN]), 64'(d));
            check($sformatf("rd_busy%0d x%0d", p, a), 64'(rd_busy[p]), 64'(b));
        end
    endtask

    task automatic model_edge();
        if (clear_req) begin
            m_clr = NREGS;
            for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
        end else if (m_clr > 0) begin
            m_clr--;
            if (m_clr == 0)
                for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
        end else begin
            if (wb_en && wb_addr != 0) begin
                m_mem[wb_addr]  = wb_data;
                m_busy[wb_addr] = 0;
            end
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        clear_req = 1'b0;
        alloc_en  = 1'b0;
        wb_en     = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0 +: AW]  = a0[AW-1:0];
        rd_addr[AW +: AW] = a1[AW-1:0];
    endtask

    task automatic do_wb(input int a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a[AW-1:0];
        wb_data = d;
    endtask

    task automatic do_alloc(input int a);
        alloc_en   = 1'b1;
        alloc_addr = a[AW-1:0];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int a;
        idle();
        rd_addr    = '0;
        alloc_addr = '0;
        wb_addr    = '0;
        wb_data    = '0;
        s_clear_req  = 1'b0;
        s_alloc_en   = 1'b0;
        s_alloc_addr = '0;
        s_wb_en      = 1'b0;
        s_wb_addr    = '0;
        s_wb_data    = '0;
        m_clr = NREGS;
        for (int i = 0; i < NREGS; i++) m_busy[i] = 0;

        set_rd(5, 9);
        #23;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clear phase with garbage traffic that must be ignored.
        for (int i = 0; i < NREGS; i++) begin
            do_wb(1 + ($urandom % 31), $urandom);
            do_alloc(1 + ($urandom % 31));
            set_rd($urandom % 32, $urandom % 32);
            step();
        end
        idle();
        for (int i = 0; i < NREGS; i += 2) begin
            set_rd(i, i + 1);
            step();
        end

        // Basic write/read and x0 handling.
        set_rd(5, 5);
        do_wb(5, 32'hDEADBEEF);
        step();
        idle();
        step();
        set_rd(0, 0);
        do_wb(0, 32'h1234);
        do_alloc(0);
        step();
        idle();
        step();

        // Scoreboard.
        set_rd(7, 7);
        do_alloc(7);
        step();
        idle();
        step();
        do_wb(7, 32'h55);
        step();
        idle();
        step();
        do_alloc(7);
        do_wb(7, 32'h66);
        step();
        idle();
        step();

        // Same-cycle writeback visibility.
        set_rd(3, 3);
        do_wb(3, 32'hA5A5A5A5);
        step();
        idle();
        step();

        // Flush mid-run.
        for (int i = 1; i <= 4; i++) begin
            do_alloc(i);
            step();
        end
        idle();
        set_rd(1, 2);
        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        lat = 0;
        while (!ready && lat < 100) begin
            step();
            lat++;
        end
        check("flush_latency", 64'(lat), 64'(NREGS));
        set_rd(1, 2);
        step();
        set_rd(3, 4);
        step();

        // Randomized traffic with clustered addresses to force collisions.
        for (int i = 0; i < 2000; i++) begin
            idle();
            a = ($urandom % 4 == 0) ? ($urandom % 32) : ($urandom % 6);
            if ($urandom % 2) do_wb(a, $urandom);
            a = ($urandom % 4 == 0) ? ($urandom % 32) : ($urandom % 6);
            if ($urandom % 3 == 0) do_alloc(a);
            clear_req = ($urandom % 250 == 0);
            if ($urandom % 3 == 0) set_rd(wb_addr, wb_addr);
            else set_rd($urandom % 6, $urandom % 32);
            step();
        end
        idle();

        // Wide/narrow instance: clear length and three independent ports.
        s_clear_req = 1'b1;
        @(posedge clk);
        #1;
        s_clear_req = 1'b0;
        check("p16_ready_drop", 64'(s_ready), 64'd0);
        lat = 0;
        while (!s_ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("p16_clear_latency", 64'(lat), 64'd16);
        s_wb_en = 1'b1;
        s_wb_addr = 4'd1;
        s_wb_data = 64'h1111_2222_3333_4444;
        @(posedge clk);
        #1;
        s_wb_addr = 4'd2;
        s_wb_data = 64'h5555_6666_7777_8888;
        @(posedge clk);
        #1;
        s_wb_addr = 4'd15;
        s_wb_data = 64'hFEDC_BA98_7654_3210;
        @(posedge clk);
        #1;
        s_wb_en = 1'b0;
        s_alloc_en = 1'b1;
        s_alloc_addr = 4'd2;
        @(posedge clk);
        #1;
        s_alloc_en = 1'b0;
        s_rd_addr = {4'd15, 4'd2, 4'd1};
        #1;
        check("p16_port0", s_rd_data[0 +: 64], 64'h1111_2222_3333_4444);
        check("p16_port1", s_rd_data[64 +: 64], 64'h5555_6666_7777_8888);
        check("p16_port2", s_rd_data[128 +: 64], 64'hFEDC_BA98_7654_3210);
        check("p16_busy", 64'(s_rd_busy), 64'b010);
        s_rd_addr = {4'd15, 4'd15, 4'd15};
        #1;
        check("p16_same0", s_rd_data[0 +: 64], 64'hFEDC_BA98_7654_3210);
        check("p16_same1", s_rd_data[64 +: 64], 64'hFEDC_BA98_7654_3210);
        check("p16_same2", s_rd_data[128 +: 64], 64'hFEDC_BA98_7654_3210);
        s_rd_addr = {4'd0, 4'd9, 4'd14};
        #1;
        check("p16_x14", s_rd_data[0 +: 64], 64'd0);
        check("p16_x9", s_rd_data[64 +: 64], 64'd0);
        check("p16_x0", s_rd_data[128 +: 64], 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
